// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int          PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetchState_t;

  // Queue entry layout at the default 32-bit widths; the top packs {pc, data} in this order.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; 1-cycle write-to-read latency, push to a full FIFO is accepted only with a pop.
// No internal backpressure beyond the full/empty flags; clear has priority over push and pop.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushDat,
  input  logic             pop,
  output logic [WIDTH-1:0] popDat,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign popDat = mem[rdPtr];

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushDat;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (doPop) rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: issues in-order word reads and queues {pc, word} for decode; request to inst_valid = L+1 cycles.
// Requests are credit-limited so outstanding + queued never exceeds QDEPTH; responses are never backpressured.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int CNT_W = $clog2(QDEPTH + 1);

  fetchState_t              state;
  fetchState_t              nextState;
  logic                     reqValid;
  logic [ADDR_W-1:0]        fetchPc;
  logic [CNT_W-1:0]         dropCnt;
  logic [CNT_W-1:0]         pendCount;
  logic [CNT_W-1:0]         qCount;
  logic [CNT_W:0]           nextPend;
  logic [CNT_W:0]           nextQ;
  logic [ADDR_W-1:0]        pendPc;
  logic [ADDR_W+DATA_W-1:0] qHead;
  logic                     reqFire;
  logic                     instFire;
  logic                     qPush;
  logic                     pendFull;
  logic                     pendEmpty;
  logic                     qFull;
  logic                     qEmpty;

  assign reqFire        = reqValid && imem_req_ready;
  assign instFire       = inst_valid && inst_ready;
  assign qPush          = imem_rsp_valid && (dropCnt == '0);
  assign imem_req_valid = reqValid;
  assign imem_req_addr  = fetchPc;
  assign inst_valid     = !qEmpty;
  assign inst_pc        = qHead[ADDR_W+DATA_W-1:DATA_W];
  assign inst_data      = qHead[DATA_W-1:0];

  // Occupancy after this cycle; the pending-PC count doubles as the outstanding-request count.
  always_comb begin
    nextPend  = {1'b0, pendCount} + (CNT_W+1)'(reqFire) - (CNT_W+1)'(imem_rsp_valid);
    nextQ     = {1'b0, qCount} + (CNT_W+1)'(qPush) - (CNT_W+1)'(instFire);
    nextState = state;
    if (redirect_valid) begin
      nextQ     = '0;
      nextState = (nextPend != '0) ? FLUSH : RUN;
    end else if (state == FLUSH && dropCnt == '0) begin
      nextState = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      fetchPc  <= RESET_PC;
      dropCnt  <= '0;
      reqValid <= 1'b0;
    end else begin
      state    <= nextState;
      reqValid <= (nextState == RUN) && ((nextPend + nextQ) < (CNT_W+1)'(QDEPTH));
      if (redirect_valid) begin
        fetchPc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        dropCnt <= nextPend[CNT_W-1:0];
      end else begin
        if (reqFire) fetchPc <= fetchPc + ADDR_W'(PC_STEP);
        if (imem_rsp_valid && dropCnt != '0) dropCnt <= dropCnt - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(QDEPTH), .WIDTH(ADDR_W)) pendFifo (
    .clk(clk), .rst(rst),
    .push(reqFire), .pushDat(fetchPc),
    .pop(imem_rsp_valid), .popDat(pendPc),
    .clear(1'b0), .count(pendCount), .full(pendFull), .empty(pendEmpty)
  );

  fetch_fifo #(.DEPTH(QDEPTH), .WIDTH(ADDR_W + DATA_W)) instQueue (
    .clk(clk), .rst(rst),
    .push(qPush), .pushDat({pendPc, imem_rsp_data}),
    .pop(instFire), .popDat(qHead),
    .clear(redirect_valid), .count(qCount), .full(qFull), .empty(qEmpty)
  );

  // A response with nothing outstanding is a memory-side protocol error.
  rspHasOwner: assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> !pendEmpty);
  reqHasSlot:  assert property (@(posedge clk) disable iff (!rst) reqFire |-> !pendFull);
  rspHasSlot:  assert property (@(posedge clk) disable iff (!rst) (qPush && !redirect_valid) |-> (!qFull || instFire));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: memory model with fixed latency, stream scoreboard on the decode side, second instance for wrap-around reset PC.
module tb_instruction_fetch_unit;
  logic        clk;
  logic        rst  = 1'b1;
  logic        rst2 = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  logic        req2Valid;
  logic [31:0] req2Addr;
  logic        rsp2Valid = 1'b0;
  logic        inst2Valid;
  logic [31:0] inst2Data;
  logic [31:0] inst2Pc;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .rst(rst2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(req2Valid), .imem_req_ready(1'b1), .imem_req_addr(req2Addr),
    .imem_rsp_valid(rsp2Valid), .imem_rsp_data(32'h0000_0013),
    .inst_valid(inst2Valid), .inst_ready(1'b1), .inst_data(inst2Data), .inst_pc(inst2Pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  memReq_t     memQ[$];
  logic [31:0] reqLog[$];
  int          reqCyc[$];
  logic [31:0] gotPc[$];
  logic [31:0] addr2Log[$];
  logic [31:0] expPc       = 32'h0;
  int          cyc         = 0;
  int          memLat      = 1;
  logic        readyRand   = 1'b0;
  int          maxInflight = 0;
  int          relCyc      = 0;
  int          checkCount  = 0;
  int          errorCount  = 0;
  logic        hs2         = 1'b0;

  function automatic logic [31:0] dataFn(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qAt(logic [31:0] q[$], int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int cAt(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyReset(int lat);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    reqLog.delete();
    reqCyc.delete();
    gotPc.delete();
    maxInflight = 0;
    expPc       = 32'h0;
    memLat      = lat;
    readyRand   = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    relCyc = cyc;
    step();
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: in-order, fixed latency, accepts when ready.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      memQ.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      imem_req_ready = readyRand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (memQ.size() > 0 && memQ[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = dataFn(memQ[0].addr);
        void'(memQ.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        memQ.push_back('{imem_req_addr, cyc + memLat});
        reqLog.push_back(imem_req_addr);
        reqCyc.push_back(cyc);
      end
    end
  end

  // Latency-1 responder for the wrap-around instance.
  initial forever begin
    @(negedge clk);
    if (!rst2) begin
      rsp2Valid = 1'b0;
      hs2       = 1'b0;
    end else begin
      rsp2Valid = hs2;
      hs2       = req2Valid;
      if (hs2) addr2Log.push_back(req2Addr);
    end
  end

  // Decode-side scoreboard: consecutive PCs from the last redirect target, data tied to PC.
  initial forever begin
    @(negedge clk);
    if (rst && inst_valid && inst_ready) begin
      checkVal("instPc", inst_pc, expPc);
      checkVal("instData", inst_data, dataFn(expPc));
      gotPc.push_back(inst_pc);
      expPc = expPc + 32'd4;
    end
    if (rst && redirect_valid) expPc = redirect_pc & ~32'h3;
    if (reqLog.size() - gotPc.size() > maxInflight) maxInflight = reqLog.size() - gotPc.size();
  end

  initial begin
    int n0;
    int g0;
    int rCyc;
    int stale;
    logic        found;
    logic [31:0] hsAddr;

    // Reset state
    #1 rst = 1'b0; rst2 = 1'b0;
    #2;
    checkVal("rstReqValid", 32'(imem_req_valid), 32'h0);
    checkVal("rstInstValid", 32'(inst_valid), 32'h0);
    checkVal("rstInstData", inst_data, 32'h0);
    checkVal("rstInstPc", inst_pc, 32'h0);
    checkVal("rstReqAddr", imem_req_addr, 32'h0);
    checkVal("rstWrapAddr", req2Addr, 32'hFFFF_FFF8);

    // Streaming, latency 1
    inst_ready = 1'b1;
    applyReset(1);
    rst2 = 1'b1;
    step(12);
    checkVal("t1Req0", qAt(reqLog, 0), 32'h0);
    checkVal("t1Req1", qAt(reqLog, 1), 32'h4);
    checkVal("t1Req2", qAt(reqLog, 2), 32'h8);
    checkVal("t1FirstReqCyc", 32'(cAt(reqCyc, 0)), 32'(relCyc + 1));
    checkVal("t1Pc0", qAt(gotPc, 0), 32'h0);
    checkVal("t1Pc1", qAt(gotPc, 1), 32'h4);
    checkVal("t1Pc2", qAt(gotPc, 2), 32'h8);
    checkVal("t1MaxInflight", 32'(maxInflight), 32'd2);
    checkVal("t1Wrap0", qAt(addr2Log, 0), 32'hFFFF_FFF8);
    checkVal("t1Wrap1", qAt(addr2Log, 1), 32'hFFFF_FFFC);
    checkVal("t1Wrap2", qAt(addr2Log, 2), 32'h0000_0000);

    // Decode stalled: credit limit holds requests at two
    inst_ready = 1'b0;
    applyReset(1);
    step(10);
    checkVal("t2ReqCount", 32'(reqLog.size()), 32'd2);
    checkVal("t2ReqIdle", 32'(imem_req_valid), 32'h0);
    checkVal("t2InstValid", 32'(inst_valid), 32'h1);
    checkVal("t2NoneTaken", 32'(gotPc.size()), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && reqLog.size() < 3; i++) step();
    step();
    checkVal("t2Resume", qAt(reqLog, 2), 32'h8);
    checkVal("t2Pc0", qAt(gotPc, 0), 32'h0);
    checkVal("t2Pc1", qAt(gotPc, 1), 32'h4);

    // Redirect with two requests outstanding, latency 3
    applyReset(3);
    for (int i = 0; i < 10 && memQ.size() != 2; i++) step();
    checkVal("t3TwoOutstanding", 32'(memQ.size()), 32'd2);
    checkVal("t3ReqIdle", 32'(imem_req_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    rCyc           = cyc;
    n0             = reqLog.size();
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && reqLog.size() <= n0; i++) step();
    checkVal("t3NewAddr", qAt(reqLog, n0), 32'h0000_0100);
    checkVal("t3FlushCycles", 32'(cAt(reqCyc, n0)), 32'(rCyc + 4));
    for (int i = 0; i < 20 && gotPc.size() == 0; i++) step();
    checkVal("t3FirstPc", qAt(gotPc, 0), 32'h0000_0100);

    // Random ready with redirects, then redirect on a cycle with both a request and a response
    applyReset(1);
    readyRand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      redirect_valid = (i == 10) || (i == 20);
      redirect_pc    = (i == 10) ? 32'h0000_2000 : 32'h0000_3006;
      inst_ready     = 1'($urandom_range(0, 1));
      step();
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    readyRand      = 1'b0;
    found          = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req_valid && memQ.size() > 0 && memQ[0].due == cyc) found = 1'b1;
      else step();
    end
    checkVal("t5Found", 32'(found), 32'h1);
    hsAddr         = imem_req_addr;
    n0             = reqLog.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    step();
    redirect_valid = 1'b0;
    g0             = gotPc.size();
    step(10);
    checkVal("t5HsAddr", qAt(reqLog, n0), hsAddr);
    checkVal("t5FirstPc", qAt(gotPc, g0), 32'h0000_4000);
    stale = 0;
    for (int i = g0; i < gotPc.size(); i++) if (gotPc[i] == hsAddr) stale++;
    checkVal("t5Stale", 32'(stale), 32'd0);
    checkVal("t5Progress", 32'(gotPc.size() - g0 >= 3), 32'h1);

    // Asynchronous reset mid-burst
    #2;
    checkVal("t6Busy", 32'(imem_req_valid | inst_valid), 32'h1);
    rst = 1'b0;
    #1;
    checkVal("t6ReqValid", 32'(imem_req_valid), 32'h0);
    checkVal("t6InstValid", 32'(inst_valid), 32'h0);
    checkVal("t6ReqAddr", imem_req_addr, 32'h0);
    applyReset(1);
    for (int i = 0; i < 10 && reqLog.size() == 0; i++) step();
    checkVal("t6FirstReq", qAt(reqLog, 0), 32'h0);
    checkVal("t6FirstReqCyc", 32'(cAt(reqCyc, 0)), 32'(relCyc + 1));
    step(5);
    checkVal("t6FirstPc", qAt(gotPc, 0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
